alu_instr_sequencer: RTL and testbench

- Program-driven controller for the ALU/regfile datapath. It replaces manual probe driving of that datapath.
- Holds a small instruction memory and runs a FETCH/EXEC/WB loop.
- Decodes 16-bit instructions into ALUOp, ALUSrc1/2, register addresses, immediate and RegWrite.
- Consumes alu_result, ovf and take_branch back from the datapath to perform writeback and branching.

---
 rtl/alu_instr_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_alu_instr_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_instr_sequencer.sv
// Program-driven controller for the ALU/regfile datapath: holds a small instruction
// memory, runs a FETCH/EXEC/WB loop and sequences writeback and branching.
module alu_instr_sequencer #(
    parameter int         DEPTH     = 256,
    parameter logic [3:0] ALUOP_ADD = 4'h0,
    parameter logic [3:0] ALUOP_BEQ = 4'hA,
    localparam int        AW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [15:0]   prog_data,
    input  logic          start,
    input  logic [15:0]   alu_result,
    input  logic          alu_ovf,
    input  logic          take_branch,
    output logic [3:0]    ALUOp,
    output logic          ALUSrc1,
    output logic          ALUSrc2,
    output logic [15:0]   imm,
    output logic [2:0]    rd_addr1,
    output logic [2:0]    rd_addr2,
    output logic [2:0]    wr_addr,
    output logic [15:0]   wr_data,
    output logic          RegWrite,
    output logic          busy,
    output logic          done,
    output logic          ovf_sticky,
    output logic          illegal,
    output logic [15:0]   retired,
    output logic [AW-1:0] pc
);

    typedef enum logic [2:0] {IDLE, FETCH, EXEC, WB, HALT} state_t;

    localparam logic [3:0] OP_HALT = 4'h0;
    localparam logic [3:0] OP_ALUR = 4'h1;
    localparam logic [3:0] OP_ADDI = 4'h2;
    localparam logic [3:0] OP_LI   = 4'h3;
    localparam logic [3:0] OP_BR   = 4'h4;
    localparam logic [3:0] OP_JMP  = 4'h5;

    state_t state, state_next;

    logic [15:0]   mem [DEPTH];
    logic [15:0]   instr_q;
    logic [15:0]   result_q;
    logic          ovf_q;
    logic          branch_q;

    logic [3:0]    opcode;
    logic [3:0]    dec_aluop;
    logic          dec_src1;
    logic          dec_src2;
    logic [15:0]   dec_imm;
    logic [2:0]    dec_ra1;
    logic [2:0]    dec_ra2;
    logic [2:0]    dec_wa;
    logic          dec_write;
    logic          dec_illegal;

    logic [AW-1:0] pc_inc;
    logic [AW-1:0] br_off;
    logic [AW-1:0] pc_wb;
    logic [15:0]   retired_inc;

    assign opcode      = instr_q[15:12];
    assign pc_inc      = pc + AW'(1);
    assign br_off      = AW'($signed(instr_q[5:0]));
    assign retired_inc = (retired == 16'hFFFF) ? retired : retired + 16'd1;

    always_comb begin
        dec_aluop   = 4'h0;
        dec_src1    = 1'b0;
        dec_src2    = 1'b0;
        dec_imm     = 16'h0;
        dec_ra1     = 3'd0;
        dec_ra2     = 3'd0;
        dec_wa      = 3'd0;
        dec_write   = 1'b0;
        dec_illegal = 1'b0;
        case (opcode)
            OP_HALT: ;
            OP_ALUR: begin
                dec_ra1   = instr_q[11:9];
                dec_ra2   = instr_q[8:6];
                dec_wa    = instr_q[5:3];
                dec_aluop = {1'b0, instr_q[2:0]};
                dec_write = 1'b1;
            end
            OP_ADDI: begin
                dec_ra1   = instr_q[11:9];
                dec_wa    = instr_q[8:6];
                dec_imm   = {{10{instr_q[5]}}, instr_q[5:0]};
                dec_src2  = 1'b1;
                dec_aluop = ALUOP_ADD;
                dec_write = 1'b1;
            end
            OP_LI: begin
                dec_wa    = instr_q[11:9];
                dec_imm   = {{7{instr_q[8]}}, instr_q[8:0]};
                dec_src1  = 1'b1;
                dec_src2  = 1'b1;
                dec_aluop = ALUOP_ADD;
                dec_write = 1'b1;
            end
            OP_BR: begin
                dec_ra1   = instr_q[11:9];
                dec_ra2   = instr_q[8:6];
                dec_imm   = {{10{instr_q[5]}}, instr_q[5:0]};
                dec_aluop = ALUOP_BEQ;
            end
            OP_JMP: ;
            default: dec_illegal = 1'b1;
        endcase
    end

    // Branch uses the take_branch flag captured at the end of EXEC, not the live input.
    always_comb begin
        pc_wb = pc_inc;
        if (opcode == OP_BR && branch_q) begin
            pc_wb = pc_inc + br_off;
        end else if (opcode == OP_JMP) begin
            pc_wb = instr_q[AW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ALUOp      = 4'h0;
        ALUSrc1    = 1'b0;
        ALUSrc2    = 1'b0;
        imm        = 16'h0;
        rd_addr1   = 3'd0;
        rd_addr2   = 3'd0;
        wr_addr    = 3'd0;
        wr_data    = 16'h0;
        RegWrite   = 1'b0;
        busy       = (state == FETCH) || (state == EXEC) || (state == WB);
        done       = (state == HALT);
        case (state)
            IDLE, HALT: if (start) state_next = FETCH;
            FETCH:      state_next = EXEC;
            EXEC:       state_next = (opcode == OP_HALT) ? HALT : WB;
            WB:         state_next = FETCH;
            default:    state_next = IDLE;
        endcase
        if (state == EXEC || state == WB) begin
            ALUOp    = dec_aluop;
            ALUSrc1  = dec_src1;
            ALUSrc2  = dec_src2;
            imm      = dec_imm;
            rd_addr1 = dec_ra1;
            rd_addr2 = dec_ra2;
            wr_addr  = dec_wa;
        end
        if (state == WB) begin
            RegWrite = dec_write;
            wr_data  = result_q;
        end
    end

    // Program loading is locked out while a program is running.
    always_ff @(posedge clk) begin
        if (prog_we && (state == IDLE || state == HALT)) begin
            mem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= '0;
            retired    <= 16'h0;
            ovf_sticky <= 1'b0;
            illegal    <= 1'b0;
            instr_q    <= 16'h0;
            result_q   <= 16'h0;
            ovf_q      <= 1'b0;
            branch_q   <= 1'b0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (start) begin
                        pc         <= '0;
                        ovf_sticky <= 1'b0;
                        illegal    <= 1'b0;
                    end
                end
                FETCH: instr_q <= mem[pc];
                EXEC: begin
                    result_q <= alu_result;
                    ovf_q    <= alu_ovf;
                    branch_q <= take_branch;
                    if (opcode == OP_HALT) begin
                        retired <= retired_inc;
                    end
                end
                WB: begin
                    pc      <= pc_wb;
                    retired <= retired_inc;
                    if (ovf_q && dec_write) begin
                        ovf_sticky <= 1'b1;
                    end
                    if (dec_illegal) begin
                        illegal <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Scoreboard bench for alu_instr_sequencer: a small datapath model answers the
// sequencer, expected writebacks are queued up front and checked by a monitor.
module tb_alu_instr_sequencer;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [15:0]   prog_data = 16'h0;
    logic          start = 1'b0;
    logic [15:0]   alu_result;
    logic          alu_ovf;
    logic          take_branch;
    logic [3:0]    ALUOp;
    logic          ALUSrc1;
    logic          ALUSrc2;
    logic [15:0]   imm;
    logic [2:0]    rd_addr1;
    logic [2:0]    rd_addr2;
    logic [2:0]    wr_addr;
    logic [15:0]   wr_data;
    logic          RegWrite;
    logic          busy;
    logic          done;
    logic          ovf_sticky;
    logic          illegal;
    logic [15:0]   retired;
    logic [AW-1:0] pc;

    alu_instr_sequencer #(.DEPTH(256)) dut (
        .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .start(start), .alu_result(alu_result),
        .alu_ovf(alu_ovf), .take_branch(take_branch), .ALUOp(ALUOp),
        .ALUSrc1(ALUSrc1), .ALUSrc2(ALUSrc2), .imm(imm), .rd_addr1(rd_addr1),
        .rd_addr2(rd_addr2), .wr_addr(wr_addr), .wr_data(wr_data),
        .RegWrite(RegWrite), .busy(busy), .done(done), .ovf_sticky(ovf_sticky),
        .illegal(illegal), .retired(retired), .pc(pc)
    );

    always #5 clk = ~clk;

    int cmp_count  = 0;
    int fail_count = 0;

    // Datapath stand-in: register file plus ALU, with overrides for flag injection.
    logic [15:0] regs [8];
    logic        force_ovf   = 1'b0;
    logic        force_br_en = 1'b0;
    logic        force_br    = 1'b0;
    logic [15:0] op_a;
    logic [15:0] op_b;

    always_comb begin
        op_a = ALUSrc1 ? 16'h0 : regs[rd_addr1];
        op_b = ALUSrc2 ? imm : regs[rd_addr2];
        case (ALUOp)
            4'h0:    alu_result = op_a + op_b;
            4'h1:    alu_result = op_a - op_b;
            4'h2:    alu_result = op_a & op_b;
            4'h3:    alu_result = op_a | op_b;
            4'h4:    alu_result = op_a ^ op_b;
            default: alu_result = 16'h0;
        endcase
        take_branch = force_br_en ? force_br : (ALUOp == 4'hA && op_a == op_b);
        alu_ovf     = force_ovf;
    end

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) regs[i] <= 16'h0;
        end else if (RegWrite) begin
            regs[wr_addr] <= wr_data;
        end
    end

    typedef struct {
        logic [2:0]  addr;
        logic [15:0] data;
        logic        chk_imm;
        logic [15:0] imm;
    } wb_t;

    wb_t exp_q[$];
    int  wb_cycles[$];
    int  exp_retired;
    int  done_cycle;
    int  c;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        cmp_count++;
        if (act !== expv) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    task automatic pushWb(input logic [2:0] a, input logic [15:0] d, input logic ci, input logic [15:0] im);
        wb_t e;
        e.addr = a;
        e.data = d;
        e.chk_imm = ci;
        e.imm = im;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        wb_t e;
        if (RegWrite === 1'b1) begin
            cmp_count++;
            if (exp_q.size() == 0) begin
                fail_count++;
                $display("[TB] FAIL unexpected_write: got addr %0h data %0h, expected no write", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                checkOutput("wb_addr", 32'(wr_addr), 32'(e.addr));
                checkOutput("wb_data", 32'(wr_data), 32'(e.data));
                if (e.chk_imm) checkOutput("wb_imm", 32'(imm), 32'(e.imm));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic loadWord(input int a, input logic [15:0] d);
        prog_we   = 1'b1;
        prog_addr = AW'(a);
        prog_data = d;
        tick();
        prog_we   = 1'b0;
    endtask

    // Pulses start and runs until done; cycle 1 is the FETCH right after the start edge.
    task automatic applyStimulus(output int dcyc);
        int cc;
        wb_cycles.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        cc = 1;
        while (done !== 1'b1 && cc < 400) begin
            if (RegWrite === 1'b1) wb_cycles.push_back(cc);
            tick();
            cc++;
        end
        dcyc = (done === 1'b1) ? cc : -1;
        checkOutput("run_reaches_done", 32'(done), 32'd1);
    endtask

    task automatic checkIdleAfterReset();
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_pc", 32'(pc), 32'd0);
        checkOutput("rst_retired", 32'(retired), 32'd0);
        checkOutput("rst_regwrite", 32'(RegWrite), 32'd0);
        checkOutput("rst_illegal", 32'(illegal), 32'd0);
        checkOutput("rst_ovf_sticky", 32'(ovf_sticky), 32'd0);
        checkOutput("rst_aluop", 32'(ALUOp), 32'd0);
        checkOutput("rst_imm", 32'(imm), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checkIdleAfterReset();
        exp_retired = 0;

        // LI r1,#5; LI r2,#3; ALUR add r3=r1+r2; HALT
        loadWord(0, 16'h3205);
        loadWord(1, 16'h3403);
        loadWord(2, 16'h1298);
        loadWord(3, 16'h0000);
        pushWb(3'd1, 16'd5, 1'b1, 16'd5);
        pushWb(3'd2, 16'd3, 1'b1, 16'd3);
        pushWb(3'd3, 16'd8, 1'b0, 16'd0);
        applyStimulus(done_cycle);
        exp_retired += 4;
        checkOutput("a_done_cycle", 32'(done_cycle), 32'd12);
        checkOutput("a_wb_count", 32'(wb_cycles.size()), 32'd3);
        if (wb_cycles.size() == 3) begin
            checkOutput("a_wb_cycle0", 32'(wb_cycles[0]), 32'd3);
            checkOutput("a_wb_cycle1", 32'(wb_cycles[1]), 32'd6);
            checkOutput("a_wb_cycle2", 32'(wb_cycles[2]), 32'd9);
        end
        checkOutput("a_retired", 32'(retired), 32'(exp_retired));
        checkOutput("a_pc_at_halt", 32'(pc), 32'd3);
        checkOutput("a_illegal", 32'(illegal), 32'd0);

        // LI r1,#-1; ADDI r2,r1,#-32; ALUR sub r3=r1-r2; HALT
        loadWord(0, 16'h33FF);
        loadWord(1, 16'h22A0);
        loadWord(2, 16'h1299);
        loadWord(3, 16'h0000);
        pushWb(3'd1, 16'hFFFF, 1'b1, 16'hFFFF);
        pushWb(3'd2, 16'hFFDF, 1'b1, 16'hFFE0);
        pushWb(3'd3, 16'h0020, 1'b0, 16'h0);
        applyStimulus(done_cycle);
        exp_retired += 4;
        checkOutput("b_done_cycle", 32'(done_cycle), 32'd12);
        checkOutput("b_retired", 32'(retired), 32'(exp_retired));

        // ALUR add r4=r1+r2 with overflow injected; HALT
        loadWord(0, 16'h12A0);
        loadWord(1, 16'h0000);
        force_ovf = 1'b1;
        pushWb(3'd4, 16'hFFDE, 1'b0, 16'h0);
        applyStimulus(done_cycle);
        exp_retired += 2;
        checkOutput("ovf_done_cycle", 32'(done_cycle), 32'd6);
        checkOutput("ovf_sticky_alur", 32'(ovf_sticky), 32'd1);
        checkOutput("ovf_retired", 32'(retired), 32'(exp_retired));

        // JMP 4; BR r0,r0,-2 at pc=4; HALT at 3 and 5; overflow still injected
        loadWord(0, 16'h5004);
        loadWord(3, 16'h0000);
        loadWord(4, 16'h403E);
        loadWord(5, 16'h0000);
        force_br_en = 1'b1;
        force_br    = 1'b1;
        applyStimulus(done_cycle);
        exp_retired += 3;
        checkOutput("br_taken_pc", 32'(pc), 32'd3);
        checkOutput("br_taken_done_cycle", 32'(done_cycle), 32'd9);
        checkOutput("br_taken_writes", 32'(wb_cycles.size()), 32'd0);
        checkOutput("br_ovf_sticky", 32'(ovf_sticky), 32'd0);
        checkOutput("br_taken_retired", 32'(retired), 32'(exp_retired));
        force_br = 1'b0;
        applyStimulus(done_cycle);
        exp_retired += 3;
        checkOutput("br_not_taken_pc", 32'(pc), 32'd5);
        checkOutput("br_not_taken_writes", 32'(wb_cycles.size()), 32'd0);
        checkOutput("br_not_taken_ovf", 32'(ovf_sticky), 32'd0);
        checkOutput("br_not_taken_retired", 32'(retired), 32'(exp_retired));
        force_br_en = 1'b0;
        force_ovf   = 1'b0;

        // JMP 0xFF; undefined opcode 0x9 at 0xFF wraps pc to 0
        loadWord(0, 16'h50FF);
        loadWord(255, 16'h9000);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        checkOutput("wrap_pc_jmp", 32'(pc), 32'hFF);
        for (int k = 0; k < 3; k++) tick();
        checkOutput("wrap_pc_after_nop", 32'(pc), 32'd0);
        checkOutput("wrap_illegal", 32'(illegal), 32'd1);
        checkOutput("wrap_busy", 32'(busy), 32'd1);
        checkOutput("wrap_retired", 32'(retired), 32'(exp_retired + 2));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkIdleAfterReset();

        // Reset during the WB of the second instruction, then restart
        loadWord(0, 16'h3205);
        loadWord(1, 16'h3403);
        loadWord(2, 16'h1298);
        loadWord(3, 16'h0000);
        pushWb(3'd1, 16'd5, 1'b1, 16'd5);
        pushWb(3'd2, 16'd3, 1'b1, 16'd3);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        checkOutput("mid_wb2_regwrite", 32'(RegWrite), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("mid_rst_regwrite", 32'(RegWrite), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_pc", 32'(pc), 32'd0);
        checkOutput("mid_rst_retired", 32'(retired), 32'd0);

        // Same-cycle load of LI r1,#7 with start; later load/start while busy are ignored
        pushWb(3'd1, 16'd7, 1'b1, 16'd7);
        pushWb(3'd2, 16'd3, 1'b1, 16'd3);
        pushWb(3'd3, 16'd10, 1'b0, 16'd0);
        prog_we   = 1'b1;
        prog_addr = 8'd0;
        prog_data = 16'h3207;
        start     = 1'b1;
        tick();
        prog_we = 1'b0;
        start   = 1'b0;
        c = 1;
        while (done !== 1'b1 && c < 400) begin
            if (c == 4) begin
                prog_we   = 1'b1;
                prog_addr = 8'd3;
                prog_data = 16'h3E01;
                start     = 1'b1;
            end else begin
                prog_we = 1'b0;
                start   = 1'b0;
            end
            tick();
            c++;
        end
        prog_we = 1'b0;
        start   = 1'b0;
        checkOutput("rerun_done", 32'(done), 32'd1);
        checkOutput("rerun_done_cycle", 32'(c), 32'd12);
        checkOutput("rerun_retired", 32'(retired), 32'd4);
        checkOutput("rerun_pc", 32'(pc), 32'd3);

        tick();
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule
